// File: rtl/bram_pkg.sv
// rtl/bram_pkg.sv - shared geometry constants and word/address types for bram_2048x8
package bram_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/bram_port.sv
// rtl/bram_port.sv - one RAM port: write-strobe decode and registered read output
import bram_pkg::*;

module bram_port (
    input  logic  CLK,
    input  logic  RST,
    input  logic  ce,
    input  logic  we,
    input  data_t wem,
    input  data_t rd_word,
    output data_t wstrb,
    output data_t q
);

    // Per-bit strobes are only live on an enabled write, so a parked port never disturbs the array
    assign wstrb = (ce && we) ? wem : '0;

    // Output register: rd_word is the pre-edge array word, which gives read-first on writes
    always_ff @(posedge CLK) begin
        if (RST) begin
            q <= '0;
        end else if (ce) begin
            q <= rd_word;
        end
    end

endmodule

// File: rtl/bram_2048x8.sv
// rtl/bram_2048x8.sv - true dual-port 2048x8 synchronous RAM with per-bit write masks
import bram_pkg::*;

module bram_2048x8 (
    input  logic  CLK,
    input  logic  RST,
    input  logic  CE0,
    input  addr_t A0,
    input  data_t D0,
    input  logic  WE0,
    input  data_t WEM0,
    output data_t Q0,
    input  logic  CE1,
    input  addr_t A1,
    input  data_t D1,
    input  logic  WE1,
    input  data_t WEM1,
    output data_t Q1
);

    data_t mem [0:DEPTH-1];

    data_t rd_word0;
    data_t rd_word1;
    data_t wstrb0;
    data_t wstrb1;

    assign rd_word0 = mem[A0];
    assign rd_word1 = mem[A1];

    bram_port u_port0 (
        .CLK     (CLK),
        .RST     (RST),
        .ce      (CE0),
        .we      (WE0),
        .wem     (WEM0),
        .rd_word (rd_word0),
        .wstrb   (wstrb0),
        .q       (Q0)
    );

    bram_port u_port1 (
        .CLK     (CLK),
        .RST     (RST),
        .ce      (CE1),
        .we      (WE1),
        .wem     (WEM1),
        .rd_word (rd_word1),
        .wstrb   (wstrb1),
        .q       (Q1)
    );

    // Bit-granular array update; port 1 is ordered last so it owns bits both ports strobe
    always_ff @(posedge CLK) begin
        for (int i = 0; i < DATA_W; i++) begin
            if (wstrb0[i]) begin
                mem[A0][i] <= D0[i];
            end
            if (wstrb1[i]) begin
                mem[A1][i] <= D1[i];
            end
        end
    end

endmodule

// File: tb/tb_bram_2048x8.sv
// tb/tb_bram_2048x8.sv - directed and randomized self-checking bench for bram_2048x8
module tb_bram_2048x8;

    logic        CLK;
    logic        RST;
    logic        CE0;
    logic [10:0] A0;
    logic [7:0]  D0;
    logic        WE0;
    logic [7:0]  WEM0;
    logic [7:0]  Q0;
    logic        CE1;
    logic [10:0] A1;
    logic [7:0]  D1;
    logic        WE1;
    logic [7:0]  WEM1;
    logic [7:0]  Q1;

    int checks;
    int errors;

    logic [7:0] model [0:2047];
    logic [7:0] exp_q0;
    logic [7:0] exp_q1;

    bram_2048x8 dut (
        .CLK  (CLK),
        .RST  (RST),
        .CE0  (CE0),
        .A0   (A0),
        .D0   (D0),
        .WE0  (WE0),
        .WEM0 (WEM0),
        .Q0   (Q0),
        .CE1  (CE1),
        .A1   (A1),
        .D1   (D1),
        .WE1  (WE1),
        .WEM1 (WEM1),
        .Q1   (Q1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive both ports, advance the reference model, then compare outputs
    task automatic cyc(input logic rst,
                       input logic ce0, input logic we0, input logic [10:0] a0,
                       input logic [7:0] d0, input logic [7:0] wem0,
                       input logic ce1, input logic we1, input logic [10:0] a1,
                       input logic [7:0] d1, input logic [7:0] wem1,
                       input bit do_check);
        logic [7:0] n0;
        logic [7:0] n1;
        RST = rst;
        CE0 = ce0; WE0 = we0; A0 = a0; D0 = d0; WEM0 = wem0;
        CE1 = ce1; WE1 = we1; A1 = a1; D1 = d1; WEM1 = wem1;
        n0 = rst ? 8'h00 : (ce0 ? model[a0] : exp_q0);
        n1 = rst ? 8'h00 : (ce1 ? model[a1] : exp_q1);
        if (ce0 && we0) model[a0] = (model[a0] & ~wem0) | (d0 & wem0);
        if (ce1 && we1) model[a1] = (model[a1] & ~wem1) | (d1 & wem1);
        @(posedge CLK);
        #1;
        exp_q0 = n0;
        exp_q1 = n1;
        if (do_check) begin
            chk8("q0_model", Q0, exp_q0);
            chk8("q1_model", Q1, exp_q1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_q0 = 8'h00;
        exp_q1 = 8'h00;
        RST = 1'b0;
        CE0 = 1'b0; WE0 = 1'b0; A0 = '0; D0 = '0; WEM0 = '0;
        CE1 = 1'b0; WE1 = 1'b0; A1 = '0; D1 = '0; WEM1 = '0;
        @(posedge CLK);
        #1;

        // Fill the whole array through both ports so every later read is defined
        for (int i = 0; i < 1024; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 11'(2 * i), 8'($urandom), 8'hFF,
                      1'b1, 1'b1, 11'(2 * i + 1), 8'($urandom), 8'hFF, 1'b0);
        end
        cyc(1'b1, 1'b0, 1'b0, 11'h000, 8'h00, 8'h00, 1'b0, 1'b0, 11'h000, 8'h00, 8'h00, 1'b1);
        chk8("init_rst_q0", Q0, 8'h00);
        chk8("init_rst_q1", Q1, 8'h00);

        // Reset clears both output registers
        cyc(1'b0, 1'b1, 1'b1, 11'h001, 8'hA5, 8'hFF, 1'b0, 1'b0, 11'h000, 8'h00, 8'h00, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 11'h001, 8'h00, 8'h00, 1'b1, 1'b0, 11'h001, 8'h00, 8'h00, 1'b1);
        chk8("pre_rst_q0", Q0, 8'hA5);
        chk8("pre_rst_q1", Q1, 8'hA5);
        cyc(1'b1, 1'b0, 1'b0, 11'h000, 8'h00, 8'h00, 1'b0, 1'b0, 11'h000, 8'h00, 8'h00, 1'b1);
        chk8("rst_q0", Q0, 8'h00);
        chk8("rst_q1", Q1, 8'h00);

        // Port 0 write then port 1 read
        cyc(1'b0, 1'b1, 1'b1, 11'h000, 8'h3C, 8'hFF, 1'b0, 1'b0, 11'h000, 8'h00, 8'h00, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 11'h000, 8'h00, 8'h00, 1'b1, 1'b0, 11'h000, 8'h00, 8'h00, 1'b1);
        chk8("wr_rd_q1", Q1, 8'h3C);

        // Partial mask write
        cyc(1'b0, 1'b1, 1'b1, 11'h005, 8'hFF, 8'hFF, 1'b0, 1'b0, 11'h000, 8'h00, 8'h00, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 11'h005, 8'h00, 8'h0F, 1'b0, 1'b0, 11'h000, 8'h00, 8'h00, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 11'h000, 8'h00, 8'h00, 1'b1, 1'b0, 11'h005, 8'h00, 8'h00, 1'b1);
        chk8("mask_q1", Q1, 8'hF0);

        // Read-first on both the writing port and the cross port
        cyc(1'b0, 1'b1, 1'b1, 11'h007, 8'h11, 8'hFF, 1'b0, 1'b0, 11'h000, 8'h00, 8'h00, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 11'h007, 8'h22, 8'hFF, 1'b1, 1'b0, 11'h007, 8'h00, 8'h00, 1'b1);
        chk8("rf_q0", Q0, 8'h11);
        chk8("rf_q1", Q1, 8'h11);
        cyc(1'b0, 1'b0, 1'b0, 11'h000, 8'h00, 8'h00, 1'b1, 1'b0, 11'h007, 8'h00, 8'h00, 1'b1);
        chk8("rf_after_q1", Q1, 8'h22);

        // Both ports write the same word; port 1 wins overlapping bits
        cyc(1'b0, 1'b1, 1'b1, 11'h7FF, 8'hAA, 8'hFF, 1'b1, 1'b1, 11'h7FF, 8'h55, 8'hF0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 11'h7FF, 8'h00, 8'h00, 1'b0, 1'b0, 11'h000, 8'h00, 8'h00, 1'b1);
        chk8("collide_q0", Q0, 8'h5A);

        // Idle port holds its output while its other inputs toggle
        cyc(1'b0, 1'b0, 1'b0, 11'h000, 8'h00, 8'h00, 1'b1, 1'b0, 11'h000, 8'h00, 8'h00, 1'b1);
        chk8("hold_start_q1", Q1, 8'h3C);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 11'h000, 8'h00, 8'h00,
                      1'b0, 1'b1, 11'($urandom), 8'($urandom), 8'($urandom), 1'b1);
            chk8("hold_q1", Q1, 8'h3C);
        end
        cyc(1'b0, 1'b0, 1'b0, 11'h000, 8'h00, 8'h00, 1'b1, 1'b0, 11'h000, 8'h00, 8'h00, 1'b1);
        chk8("hold_nowrite_q1", Q1, 8'h3C);

        // Randomized traffic, biased to a small window so collisions happen often
        for (int n = 0; n < 500; n++) begin
            logic [10:0] ra0;
            logic [10:0] ra1;
            ra0 = ($urandom_range(0, 1) == 0) ? 11'($urandom_range(0, 7)) : 11'($urandom);
            ra1 = ($urandom_range(0, 1) == 0) ? 11'($urandom_range(0, 7)) : 11'($urandom);
            cyc(($urandom_range(0, 31) == 0),
                1'($urandom), 1'($urandom), ra0, 8'($urandom), 8'($urandom),
                1'($urandom), 1'($urandom), ra1, 8'($urandom), 8'($urandom), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
